// File: rtl/div_seq.sv
// div_seq: iterative restoring divider for MIPS DIV/DIVU in the EX stage.
// Produces {remainder, quotient} after WIDTH shift-subtract iterations and
// asks the pipeline to stall while the operation is in flight.
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  input  logic               annul_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               stallreq_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_BYZERO = 2'd1,
    S_ON     = 2'd2,
    S_END    = 2'd3
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [CW-1:0]     cnt;
  logic [WIDTH-1:0]  rem;
  logic [WIDTH-1:0]  quo;
  logic [WIDTH-1:0]  dvs;
  logic              neg_q;
  logic              neg_r;

  // Datapath of one restoring iteration.
  logic [WIDTH:0]        rem_sh;
  logic signed [WIDTH:0] diff;
  logic [WIDTH-1:0]      rem_n;
  logic [WIDTH-1:0]      quo_n;

  // Two's-complement negate when requested; used for both the operand
  // magnitude on entry and the sign fix-up on exit.
  function automatic logic [WIDTH-1:0] fix_sign(input logic [WIDTH-1:0] v,
                                                input logic neg);
    return neg ? (WIDTH'(0) - v) : v;
  endfunction

  // Shift {rem, quo} left and try to subtract the divisor. The partial
  // remainder is always below the divisor, so WIDTH+1 bits hold the
  // difference with a trustworthy sign bit.
  always_comb begin
    rem_sh = {rem, quo[WIDTH-1]};
    diff   = $signed(rem_sh - {1'b0, dvs});
    if (diff >= 0) begin
      rem_n = diff[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_n = rem_sh[WIDTH-1:0];
      quo_n = {quo[WIDTH-2:0], 1'b0};
    end
  end

  // Next-state logic; cancellation wins over everything else.
  always_comb begin
    state_n = state;
    if (annul_i) begin
      state_n = S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_i) begin
            state_n = (opdata2_i == '0) ? S_BYZERO : S_ON;
          end
        end
        S_BYZERO: state_n = S_END;
        S_ON: begin
          if (cnt == CW'(WIDTH - 1)) begin
            state_n = S_END;
          end
        end
        S_END:    state_n = S_IDLE;
        default:  state_n = S_IDLE;
      endcase
    end
  end

  // State, iteration counter and operand/partial-result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_n;
      case (state)
        S_IDLE: begin
          if (start_i && !annul_i) begin
            cnt <= '0;
            rem <= '0;
            if (opdata2_i == '0) begin
              // Divide-by-zero reports an all-zero result.
              quo   <= '0;
              dvs   <= '0;
              neg_q <= 1'b0;
              neg_r <= 1'b0;
            end else begin
              quo   <= fix_sign(opdata1_i, signed_div_i & opdata1_i[WIDTH-1]);
              dvs   <= fix_sign(opdata2_i, signed_div_i & opdata2_i[WIDTH-1]);
              neg_q <= signed_div_i & (opdata1_i[WIDTH-1] ^ opdata2_i[WIDTH-1]);
              neg_r <= signed_div_i & opdata1_i[WIDTH-1];
            end
          end
        end
        S_ON: begin
          if (!annul_i) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Result is visible only during the single END cycle, with sign fix-up.
  always_comb begin
    ready_o  = (state == S_END);
    result_o = '0;
    if (state == S_END) begin
      result_o = {fix_sign(rem, neg_r), fix_sign(quo, neg_q)};
    end
  end

  // Hold the pipeline while a divide is pending and not being cancelled.
  always_comb begin
    stallreq_o = start_i & ~ready_o & ~annul_i;
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed-vector bench for div_seq with an arithmetic reference
// model and a per-cycle compare of ready/result/stall against expectations.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sgn;
  logic [31:0] a;
  logic [31:0] b;
  logic        annul;
  logic [63:0] result;
  logic        ready;
  logic        stallreq;

  int          checks   = 0;
  int          failures = 0;
  int          cyc      = 0;
  bit          chk_en   = 1'b0;
  longint      exp_ready_at = -1;
  logic [63:0] exp_res  = '0;
  longint      last_ready = -1;
  longint      prev_ready = -1;

  div_seq #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start),
    .signed_div_i (sgn),
    .opdata1_i    (a),
    .opdata2_i    (b),
    .annul_i      (annul),
    .result_o     (result),
    .ready_o      (ready),
    .stallreq_o   (stallreq)
  );

  always #5 clk = ~clk;

  // Cycle index: a value driven just after a posedge belongs to that cycle.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Reference: divide magnitudes with 64-bit integers, then apply MIPS signs.
  function automatic logic [63:0] model(input bit s, input logic [31:0] x, input logic [31:0] y);
    longint ux, uy, q, r;
    bit nx, ny;
    if (y == 32'd0) return 64'd0;
    nx = s && x[31];
    ny = s && y[31];
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    if (nx) ux = 64'sh1_0000_0000 - ux;
    if (ny) uy = 64'sh1_0000_0000 - uy;
    q = ux / uy;
    r = ux % uy;
    if (nx ^ ny) q = -q;
    if (nx) r = -r;
    return {r[31:0], q[31:0]};
  endfunction

  // Per-cycle compare against the expected pulse timing and result.
  always @(negedge clk) begin
    if (chk_en) begin
      bit er;
      er = (longint'(cyc) == exp_ready_at);
      chk("ready", {63'd0, ready}, {63'd0, er});
      chk("result", result, er ? exp_res : 64'd0);
      chk("stallreq", {63'd0, stallreq}, {63'd0, start && !er && !annul && !rst});
      if (ready === 1'b1) begin
        prev_ready = last_ready;
        last_ready = cyc;
      end
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      start = 1'b0;
      a = 32'hDEAD_BEEF;
      b = 32'h0;
    end
  endtask

  // Launch one divide (start held until the result cycle) and check the pulse.
  task automatic do_div(input bit s, input logic [31:0] x, input logic [31:0] y,
                        input logic [63:0] lit, input bit use_lit);
    int lat;
    @(posedge clk); #1;
    start = 1'b1;
    sgn   = s;
    a     = x;
    b     = y;
    lat   = (y == 32'd0) ? 2 : 33;
    exp_res      = model(s, x, y);
    exp_ready_at = cyc + lat;
    if (use_lit) chk("model_pin", exp_res, lit);
    repeat (lat) @(posedge clk);
    @(negedge clk); #1;
    chk("ready_at_latency", {63'd0, ready}, 64'd1);
    if (use_lit) chk("result_literal", result, lit);
  endtask

  // Start a divide and cancel it (annul or reset) after n cycles.
  task automatic cancel_div(input int n, input bit by_reset);
    @(posedge clk); #1;
    start = 1'b1;
    sgn   = 1'b1;
    a     = 32'hFFFF_FB2E;
    b     = 32'd5;
    exp_res      = model(1'b1, a, b);
    exp_ready_at = cyc + 33;
    repeat (n) @(posedge clk);
    #1;
    exp_ready_at = -1;
    if (by_reset) begin
      rst   = 1'b1;
      start = 1'b0;
    end else begin
      annul = 1'b1;
    end
    @(posedge clk); #1;
    rst   = 1'b0;
    annul = 1'b0;
    start = 1'b0;
    @(negedge clk); #1;
    chk("cancel_ready", {63'd0, ready}, 64'd0);
    chk("cancel_result", result, 64'd0);
    chk("cancel_stall", {63'd0, stallreq}, 64'd0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sgn   = 1'b0;
    a     = '0;
    b     = '0;
    annul = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b0;
    chk_en = 1'b1;
    @(negedge clk); #1;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    idle(3);

    do_div(1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E}, 1'b1);
    idle(2);
    do_div(1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b1);
    idle(1);
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1'b1);
    idle(1);
    do_div(1'b1, 32'd5, 32'd0, 64'd0, 1'b1);
    idle(2);

    cancel_div(10, 1'b0);
    idle(40);
    do_div(1'b0, 32'hFFFF_FFFF, 32'h10, {32'h0000_000F, 32'h0FFF_FFFF}, 1'b1);

    idle(2);
    do_div(1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 1'b1);
    do_div(1'b0, 32'd10, 32'd4, {32'd2, 32'd2}, 1'b1);
    chk("back_to_back_gap", 64'(last_ready - prev_ready), 64'd34);
    idle(2);

    cancel_div(15, 1'b1);
    idle(40);
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 1'b1);
    idle(1);

    do_div(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 1'b1);
    idle(1);
    do_div(1'b0, 32'd3, 32'd5, {32'd3, 32'd0}, 1'b1);
    do_div(1'b0, 32'hFFFF_FFFF, 32'd1, 64'd0, 1'b0);
    do_div(1'b1, 32'h8000_0000, 32'd1, 64'd0, 1'b0);
    do_div(1'b0, 32'h8765_4321, 32'hFFFF_FFFF, 64'd0, 1'b0);
    do_div(1'b0, 32'd0, 32'd0, 64'd0, 1'b0);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
